// File: rtl/tiny_bus_pkg.sv
// -----------------------------------------------------------------------------
// tiny_bus_pkg
//   Shared types and helpers for the tiny_thumb_core bus monitor.
//   - mon_state_t      : monitor state (RUN plus four absorbing terminal states)
//   - DEFAULT_SIG_ADDR : default byte address of the signature word
//   - merge_bytes()    : byte-strobed merge of write data into a word
// -----------------------------------------------------------------------------
package tiny_bus_pkg;

    typedef enum logic [2:0] {
        RUN,
        PASS,
        FAIL,
        TIMEOUT,
        HANG
    } mon_state_t;

    localparam logic [31:0] DEFAULT_SIG_ADDR = 32'h0000_0100;

    // Replace each byte of old whose strobe is set with the matching byte of wdata.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tiny_sat_counter.sv
// -----------------------------------------------------------------------------
// tiny_sat_counter
//   Up-counter that sticks at all-ones. clr has priority over inc.
//   Ports:
//     clk   : clock
//     rst_n : synchronous active-low reset (clears the count)
//     clr   : synchronous clear
//     inc   : increment enable
//     q     : current count
// -----------------------------------------------------------------------------
module tiny_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/tiny_sig_monitor.sv
// -----------------------------------------------------------------------------
// tiny_sig_monitor
//   Passive snooper on the core/memory bus. Assembles byte-strobed stores to
//   the signature word, compares the complete word to EXPECTED_SIG and reports
//   sticky PASS / FAIL / TIMEOUT / HANG status.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     mem_*        : snooped bus request (valid/we/addr/wdata/wstrb) and ready
//     done         : any terminal state reached
//     pass         : signature matched
//     fail         : signature mismatched, or bus hung
//     timeout      : run budget exhausted without completion
//     hang         : request stalled STALL_MAX cycles
//     sig_value    : signature bytes merged so far
//     lanes_seen   : signature byte lanes written since reset
//     cycle_count  : cycles spent in RUN (saturating)
//     xact_count   : completed handshakes while in RUN (saturating)
// -----------------------------------------------------------------------------
module tiny_sig_monitor
    import tiny_bus_pkg::*;
#(
    parameter logic [31:0] SIG_ADDR       = DEFAULT_SIG_ADDR,
    parameter logic [31:0] EXPECTED_SIG   = 32'h0000_00BC,
    parameter int unsigned TIMEOUT_CYCLES = 800,
    parameter int unsigned STALL_MAX      = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             hang,
    output logic [31:0]      sig_value,
    output logic [3:0]       lanes_seen,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] xact_count
);

    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_MAX - 1);

    mon_state_t  state_q, state_d;
    logic [31:0] sig_q, sig_d;
    logic [3:0]  lanes_q, lanes_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic        hang_q, hang_d;

    logic             hs, sw, run, stalled;
    logic [31:0]      merged_sig;
    logic [3:0]       merged_lanes;
    logic [CNT_W-1:0] cyc_cnt, xact_cnt, stall_cnt;
    logic             cyc_inc, xact_inc, stall_inc, stall_clr;

    always_comb begin
        hs           = mem_valid & mem_ready;
        // Shifting both sides drops the byte offset so misaligned stores still hit.
        sw           = hs & mem_we & ((mem_addr >> 2) == (SIG_ADDR >> 2));
        run          = (state_q == RUN);
        stalled      = mem_valid & ~mem_ready;
        merged_sig   = merge_bytes(sig_q, mem_wdata, mem_wstrb);
        merged_lanes = lanes_q | mem_wstrb;

        state_d = state_q;
        sig_d   = sig_q;
        lanes_d = lanes_q;

        if (run) begin
            if (sw) begin
                sig_d   = merged_sig;
                lanes_d = merged_lanes;
            end
            // Completion beats HANG beats TIMEOUT within a single cycle.
            if (sw && (merged_lanes == 4'hF)) begin
                state_d = (merged_sig == EXPECTED_SIG) ? PASS : FAIL;
            end else if (stalled && (stall_cnt == STALL_LAST)) begin
                state_d = HANG;
            end else if (cyc_cnt == CYC_LAST) begin
                state_d = TIMEOUT;
            end
        end

        // Cycles are counted only while remaining in RUN, so the count
        // freezes at TIMEOUT_CYCLES-1 on the timeout edge.
        cyc_inc   = run && (state_d == RUN);
        xact_inc  = run && hs;
        stall_inc = run && stalled;
        stall_clr = !run || !stalled;

        done_d    = (state_d != RUN);
        pass_d    = (state_d == PASS);
        fail_d    = (state_d == FAIL) || (state_d == HANG);
        timeout_d = (state_d == TIMEOUT);
        hang_d    = (state_d == HANG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            sig_q     <= '0;
            lanes_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            hang_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            lanes_q   <= lanes_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            hang_q    <= hang_d;
        end
    end

    tiny_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (cyc_inc),
        .q     (cyc_cnt)
    );

    tiny_sat_counter #(.W(CNT_W)) u_xact_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (xact_inc),
        .q     (xact_cnt)
    );

    tiny_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stall_clr),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign hang        = hang_q;
    assign sig_value   = sig_q;
    assign lanes_seen  = lanes_q;
    assign cycle_count = cyc_cnt;
    assign xact_count  = xact_cnt;

endmodule

// File: tb/tb_tiny_sig_monitor.sv
// -----------------------------------------------------------------------------
// tb_tiny_sig_monitor
//   Directed scenarios plus randomized bus traffic for tiny_sig_monitor,
//   checked against a cycle-level reference model of the monitor's rules.
// -----------------------------------------------------------------------------
module tb_tiny_sig_monitor;

    localparam int MAXC   = 65535;
    localparam int TO_CYC = 800;
    localparam int ST_MAX = 16;
    localparam logic [31:0] EXP = 32'h0000_00BC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready = 1'b0;
    logic        done, pass, fail, timeout, hang;
    logic [31:0] sig_value;
    logic [3:0]  lanes_seen;
    logic [15:0] cycle_count, xact_count;

    int checks = 0;
    int failures = 0;

    // Reference model: 0=running 1=pass 2=fail 3=timeout 4=hang
    int         m_state = 0;
    logic [7:0] m_b [4];
    logic [3:0] m_lanes = '0;
    int         m_cyc = 0, m_xact = 0, m_stall = 0;

    tiny_sig_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .hang        (hang),
        .sig_value   (sig_value),
        .lanes_seen  (lanes_seen),
        .cycle_count (cycle_count),
        .xact_count  (xact_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_word();
        return {m_b[3], m_b[2], m_b[1], m_b[0]};
    endfunction

    task automatic model_step();
        bit hs, sw;
        int nst, stall_n;
        if (!rst_n) begin
            m_state = 0; m_lanes = '0; m_cyc = 0; m_xact = 0; m_stall = 0;
            for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
        end else if (m_state == 0) begin
            hs = mem_valid && mem_ready;
            sw = hs && mem_we && ((mem_addr / 4) == (32'h100 / 4));
            nst = 0;
            if (sw) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) begin
                        m_b[i] = mem_wdata[8*i +: 8];
                        m_lanes[i] = 1'b1;
                    end
                end
            end
            stall_n = (mem_valid && !mem_ready) ? m_stall + 1 : 0;
            if (sw && m_lanes == 4'hF) nst = (m_word() == EXP) ? 1 : 2;
            else if (stall_n >= ST_MAX) nst = 4;
            else if (m_cyc == TO_CYC - 1) nst = 3;
            if (hs && m_xact < MAXC) m_xact++;
            if (nst == 0 && m_cyc < MAXC) m_cyc++;
            m_stall = stall_n;
            m_state = nst;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_bus(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic r);
        mem_valid = v; mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_ready = r;
    endtask

    task automatic idle();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (5) cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({done, pass, fail, timeout, hang, sig_value, lanes_seen, cycle_count, xact_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got d=%b p=%b f=%b t=%b h=%b sig=%h lanes=%h cyc=%0d xact=%0d, want all zero",
                     done, pass, fail, timeout, hang, sig_value, lanes_seen, cycle_count, xact_count);
        end
    endtask

    task automatic test_full_write();
        do_reset();
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_00BC, 4'hF, 1'b1);
        cycle();
        idle();
        checks++;
        if ({pass, done, fail, sig_value, lanes_seen} !== {1'b1, 1'b1, 1'b0, 32'h0000_00BC, 4'hF}) begin
            failures++;
            $display("FAIL full_write: got p=%b d=%b f=%b sig=%h lanes=%h, want p=1 d=1 f=0 sig=000000bc lanes=f",
                     pass, done, fail, sig_value, lanes_seen);
        end
        checks++;
        if (xact_count !== 16'd1) begin
            failures++;
            $display("FAIL full_write_xact: got %0d want 1", xact_count);
        end
    endtask

    task automatic test_byte_writes();
        do_reset();
        set_bus(1'b1, 1'b1, 32'h102, 32'h0000_00BC, 4'h1, 1'b1);
        cycle();
        idle();
        checks++;
        if ({lanes_seen, done, sig_value} !== {4'h1, 1'b0, 32'h0000_00BC}) begin
            failures++;
            $display("FAIL byte_first: got lanes=%h done=%b sig=%h, want lanes=1 done=0 sig=000000bc",
                     lanes_seen, done, sig_value);
        end
        // Read of the signature address and an empty-strobe write change nothing.
        set_bus(1'b1, 1'b0, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b1);
        cycle();
        set_bus(1'b1, 1'b1, 32'h101, 32'hFFFF_FFFF, 4'h0, 1'b1);
        cycle();
        idle();
        checks++;
        if ({lanes_seen, done, sig_value, xact_count} !== {4'h1, 1'b0, 32'h0000_00BC, 16'd3}) begin
            failures++;
            $display("FAIL read_and_nostrobe: got lanes=%h done=%b sig=%h xact=%0d, want lanes=1 done=0 sig=000000bc xact=3",
                     lanes_seen, done, sig_value, xact_count);
        end
        set_bus(1'b1, 1'b1, 32'h103, 32'h0000_0000, 4'hE, 1'b1);
        cycle();
        idle();
        checks++;
        if ({pass, done, lanes_seen} !== {1'b1, 1'b1, 4'hF}) begin
            failures++;
            $display("FAIL byte_second: got p=%b d=%b lanes=%h, want p=1 d=1 lanes=f", pass, done, lanes_seen);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_000A, 4'hF, 1'b1);
        cycle();
        idle();
        checks++;
        if ({fail, pass, done, hang} !== 4'b1010) begin
            failures++;
            $display("FAIL mismatch_status: got f=%b p=%b d=%b h=%b, want f=1 p=0 d=1 h=0", fail, pass, done, hang);
        end
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_00BC, 4'hF, 1'b1);
        repeat (3) cycle();
        idle();
        checks++;
        if ({sig_value, pass, fail, xact_count} !== {32'h0000_000A, 1'b0, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL mismatch_frozen: got sig=%h p=%b f=%b xact=%0d, want sig=0000000a p=0 f=1 xact=1",
                     sig_value, pass, fail, xact_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (TO_CYC - 1) cycle();
        checks++;
        if ({timeout, done, cycle_count} !== {1'b0, 1'b0, 16'd799}) begin
            failures++;
            $display("FAIL timeout_before: got t=%b d=%b cyc=%0d, want t=0 d=0 cyc=799", timeout, done, cycle_count);
        end
        cycle();
        checks++;
        if ({timeout, done, fail, pass, cycle_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd799}) begin
            failures++;
            $display("FAIL timeout_edge: got t=%b d=%b f=%b p=%b cyc=%0d, want t=1 d=1 f=0 p=0 cyc=799",
                     timeout, done, fail, pass, cycle_count);
        end
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_00BC, 4'hF, 1'b1);
        repeat (5) cycle();
        idle();
        checks++;
        if ({timeout, pass, cycle_count, lanes_seen, xact_count} !== {1'b1, 1'b0, 16'd799, 4'h0, 16'd0}) begin
            failures++;
            $display("FAIL timeout_frozen: got t=%b p=%b cyc=%0d lanes=%h xact=%0d, want t=1 p=0 cyc=799 lanes=0 xact=0",
                     timeout, pass, cycle_count, lanes_seen, xact_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_bus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        repeat (ST_MAX - 1) cycle();
        mem_ready = 1'b1;
        cycle();
        idle();
        checks++;
        if ({hang, done, xact_count} !== {1'b0, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL stall_15: got h=%b d=%b xact=%0d, want h=0 d=0 xact=1", hang, done, xact_count);
        end
        set_bus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        repeat (ST_MAX - 1) cycle();
        checks++;
        if (hang !== 1'b0) begin
            failures++;
            $display("FAIL stall_pre16: got h=%b want 0", hang);
        end
        cycle();
        idle();
        checks++;
        if ({hang, fail, done, pass, timeout} !== 5'b11100) begin
            failures++;
            $display("FAIL stall_16: got h=%b f=%b d=%b p=%b t=%b, want h=1 f=1 d=1 p=0 t=0",
                     hang, fail, done, pass, timeout);
        end
    endtask

    task automatic test_reset_coincident();
        do_reset();
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_00BC, 4'hF, 1'b1);
        cycle();
        idle();
        rst_n = 1'b0;
        cycle();
        checks++;
        if ({done, pass, fail, timeout, hang, sig_value, lanes_seen, cycle_count, xact_count} !== '0) begin
            failures++;
            $display("FAIL reset_from_pass: got d=%b p=%b sig=%h lanes=%h cyc=%0d xact=%0d, want all zero",
                     done, pass, sig_value, lanes_seen, cycle_count, xact_count);
        end
        rst_n = 1'b1;
        repeat (TO_CYC - 1) cycle();
        set_bus(1'b1, 1'b1, 32'h100, 32'h0000_00BC, 4'hF, 1'b1);
        cycle();
        idle();
        checks++;
        if ({pass, timeout, done, cycle_count} !== {1'b1, 1'b0, 1'b1, 16'd799}) begin
            failures++;
            $display("FAIL coincident: got p=%b t=%b d=%b cyc=%0d, want p=1 t=0 d=1 cyc=799",
                     pass, timeout, done, cycle_count);
        end
    endtask

    task automatic test_random();
        int hold;
        logic [31:0] d;
        hold = 0;
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            if ((m_state != 0 && $urandom_range(7) == 0) || $urandom_range(999) == 0) begin
                rst_n = 1'b0;
                idle();
            end else begin
                rst_n = 1'b1;
                if (hold == 0 && $urandom_range(99) == 0) hold = $urandom_range(20, 10);
                if (hold > 0) begin
                    set_bus(1'b1, $urandom_range(1) == 1, 32'h100, $urandom, 4'(($urandom)), 1'b0);
                    hold--;
                end else begin
                    for (int i = 0; i < 4; i++)
                        d[8*i +: 8] = ($urandom_range(1) == 1) ? EXP[8*i +: 8] : 8'($urandom);
                    set_bus($urandom_range(3) != 0, $urandom_range(3) != 0,
                            ($urandom_range(9) < 7) ? (32'h100 | 32'($urandom_range(3))) : $urandom,
                            d, 4'($urandom), $urandom_range(9) < 8);
                end
            end
            cycle();
            checks++;
            if ({done, pass, fail, timeout, hang} !==
                {m_state != 0, m_state == 1, m_state == 2 || m_state == 4, m_state == 3, m_state == 4}) begin
                failures++;
                $display("FAIL rand_status n=%0d: got d=%b p=%b f=%b t=%b h=%b, want model state %0d",
                         n, done, pass, fail, timeout, hang, m_state);
            end
            checks++;
            if ({sig_value, lanes_seen, cycle_count, xact_count} !==
                {m_word(), m_lanes, 16'(m_cyc), 16'(m_xact)}) begin
                failures++;
                $display("FAIL rand_data n=%0d: got sig=%h lanes=%h cyc=%0d xact=%0d, want sig=%h lanes=%h cyc=%0d xact=%0d",
                         n, sig_value, lanes_seen, cycle_count, xact_count, m_word(), m_lanes, m_cyc, m_xact);
            end
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
        test_reset();
        test_full_write();
        test_byte_writes();
        test_mismatch();
        test_timeout();
        test_stall();
        test_reset_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
